dispatcher: RTL

Issue stage between the decoder and the out-of-order back end. It latches one decoded instruction and allocates a ROB entry for it. It resolves both source operands from the register file, the ROB and the two CDBs, renames rd, and emits a one-cycle insert pulse to either the reservation station (ALU ops) or the load/store buffer (memory ops). Its output bundle is the producer side of the RS insert interface: ena, openum, V1/V2, Q1/Q2, pc, imm, rob_id.

---
 rtl/dispatcher.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dispatcher.sv
// Issue stage: one-entry hold register, operand resolution (reg/ROB/CDB), rename and RS/LSB insert pulse.
// Optional DSP_STAT_EN adds dispatch and stall counters.
module dispatcher #(
    parameter int ROB_ID_W = 4,
    parameter int OPENUM_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_from_dec,
    output logic                ready_to_dec,
    input  logic [OPENUM_W-1:0] openum_from_dec,
    input  logic                is_ls_from_dec,
    input  logic [4:0]          rd_from_dec,
    input  logic [4:0]          rs1_from_dec,
    input  logic [4:0]          rs2_from_dec,
    input  logic [31:0]         pc_from_dec,
    input  logic [31:0]         imm_from_dec,
    output logic [4:0]          rs1_to_reg,
    output logic [4:0]          rs2_to_reg,
    input  logic [ROB_ID_W-1:0] Q1_from_reg,
    input  logic [ROB_ID_W-1:0] Q2_from_reg,
    input  logic [31:0]         V1_from_reg,
    input  logic [31:0]         V2_from_reg,
    output logic [ROB_ID_W-1:0] Q1_to_rob,
    output logic [ROB_ID_W-1:0] Q2_to_rob,
    input  logic                ready1_from_rob,
    input  logic                ready2_from_rob,
    input  logic [31:0]         value1_from_rob,
    input  logic [31:0]         value2_from_rob,
    input  logic [ROB_ID_W-1:0] rob_id_from_rob,
    input  logic                full_from_rob,
    input  logic                full_from_rs,
    input  logic                full_from_ls,
    output logic                ena_to_rob,
    output logic [OPENUM_W-1:0] openum_to_rob,
    output logic [4:0]          rd_to_rob,
    output logic [31:0]         pc_to_rob,
    output logic                ena_to_reg,
    output logic [4:0]          rd_to_reg,
    output logic [ROB_ID_W-1:0] rob_id_to_reg,
    output logic                ena_to_rs,
    output logic                ena_to_ls,
    output logic [OPENUM_W-1:0] openum_out,
    output logic [31:0]         V1_out,
    output logic [31:0]         V2_out,
    output logic [ROB_ID_W-1:0] Q1_out,
    output logic [ROB_ID_W-1:0] Q2_out,
    output logic [31:0]         pc_out,
    output logic [31:0]         imm_out,
    output logic [ROB_ID_W-1:0] rob_id_out,
    input  logic                valid_from_rs_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb,
    input  logic [31:0]         result_from_rs_cdb,
    input  logic                valid_from_ls_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
    input  logic [31:0]         result_from_ls_cdb,
    input  logic                commit_jump_flag_from_rob,
`ifdef DSP_STAT_EN
    output logic [31:0]         dispatch_cnt_out,
    output logic [31:0]         stall_cnt_out,
`endif
    output logic                state_dbg
);

    // Handshake: a decoded instruction transfers on an edge where valid_from_dec && ready_to_dec.
    typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_e;

    state_e state, state_next;
    logic   hold_valid, flush, accept, dispatch_cond, dispatch_fire;

    logic [OPENUM_W-1:0] h_openum;
    logic                h_is_ls;
    logic [4:0]          h_rd, h_rs1, h_rs2;
    logic [31:0]         h_pc, h_imm;

    logic [ROB_ID_W+31:0] res1, res2;

    assign flush      = commit_jump_flag_from_rob;
    assign hold_valid = (state == S_HOLD);

    // ena_to_rob doubles as a one-cycle cooldown so the ROB tag and rename settle.
    assign dispatch_cond = hold_valid && !ena_to_rob && !full_from_rob &&
                           (h_is_ls ? !full_from_ls : !full_from_rs);

    always_ff @(posedge clk) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: if (valid_from_dec) state_next = S_HOLD;
            S_HOLD:  if (dispatch_cond)  state_next = S_EMPTY;
            default: state_next = S_EMPTY;
        endcase
        if (flush) state_next = S_EMPTY;
    end

    always_comb begin
        ready_to_dec  = !hold_valid;
        accept        = !hold_valid && valid_from_dec && !flush;
        dispatch_fire = dispatch_cond && !flush;
        state_dbg     = state;
    end

    function automatic logic [ROB_ID_W+31:0] resolve(
        input logic [ROB_ID_W-1:0] q_reg,
        input logic [31:0]         v_reg,
        input logic                rob_ready,
        input logic [31:0]         rob_value
    );
        if (q_reg == '0)
            return {{ROB_ID_W{1'b0}}, v_reg};
        else if (rob_ready)
            return {{ROB_ID_W{1'b0}}, rob_value};
        else if (valid_from_rs_cdb && rob_id_from_rs_cdb == q_reg)
            return {{ROB_ID_W{1'b0}}, result_from_rs_cdb};
        else if (valid_from_ls_cdb && rob_id_from_ls_cdb == q_reg)
            return {{ROB_ID_W{1'b0}}, result_from_ls_cdb};
        else
            return {q_reg, 32'd0};
    endfunction

    always_comb begin
        res1 = resolve(Q1_from_reg, V1_from_reg, ready1_from_rob, value1_from_rob);
        res2 = resolve(Q2_from_reg, V2_from_reg, ready2_from_rob, value2_from_rob);
    end

    assign rs1_to_reg = h_rs1;
    assign rs2_to_reg = h_rs2;
    assign Q1_to_rob  = Q1_from_reg;
    assign Q2_to_rob  = Q2_from_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_openum <= '0;
            h_is_ls  <= 1'b0;
            h_rd     <= '0;
            h_rs1    <= '0;
            h_rs2    <= '0;
            h_pc     <= '0;
            h_imm    <= '0;
        end else if (accept) begin
            h_openum <= openum_from_dec;
            h_is_ls  <= is_ls_from_dec;
            h_rd     <= rd_from_dec;
            h_rs1    <= rs1_from_dec;
            h_rs2    <= rs2_from_dec;
            h_pc     <= pc_from_dec;
            h_imm    <= imm_from_dec;
        end
    end

    // Pulses last one cycle; bundle data keeps its last value between dispatches.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_to_rob    <= 1'b0;
            ena_to_reg    <= 1'b0;
            ena_to_rs     <= 1'b0;
            ena_to_ls     <= 1'b0;
            openum_to_rob <= '0;
            rd_to_rob     <= '0;
            pc_to_rob     <= '0;
            rd_to_reg     <= '0;
            rob_id_to_reg <= '0;
            openum_out    <= '0;
            V1_out        <= '0;
            V2_out        <= '0;
            Q1_out        <= '0;
            Q2_out        <= '0;
            pc_out        <= '0;
            imm_out       <= '0;
            rob_id_out    <= '0;
        end else begin
            ena_to_rob <= dispatch_fire;
            ena_to_rs  <= dispatch_fire && !h_is_ls;
            ena_to_ls  <= dispatch_fire && h_is_ls;
            ena_to_reg <= dispatch_fire && (h_rd != 5'd0);
            if (dispatch_fire) begin
                openum_to_rob <= h_openum;
                rd_to_rob     <= h_rd;
                pc_to_rob     <= h_pc;
                rd_to_reg     <= h_rd;
                rob_id_to_reg <= rob_id_from_rob;
                openum_out    <= h_openum;
                {Q1_out, V1_out} <= res1;
                {Q2_out, V2_out} <= res2;
                pc_out        <= h_pc;
                imm_out       <= h_imm;
                rob_id_out    <= rob_id_from_rob;
            end
        end
    end

`ifdef DSP_STAT_EN
    // Counters survive flushes; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            dispatch_cnt_out <= '0;
            stall_cnt_out    <= '0;
        end else begin
            if (dispatch_fire)                 dispatch_cnt_out <= dispatch_cnt_out + 32'd1;
            if (hold_valid && !dispatch_cond)  stall_cnt_out    <= stall_cnt_out + 32'd1;
        end
    end
`endif

endmodule
